// File: rtl/axi_lite_master_cmd.sv
// rtl/axi_lite_master_cmd.sv - single-outstanding AXI4-Lite master driven by a command/response handshake
module axi_lite_master_cmd #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    timeout,
  output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [2:0]              M_AXI_awprot,
  output logic                    M_AXI_awvalid,
  input  logic                    M_AXI_awready,
  output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                    M_AXI_wvalid,
  input  logic                    M_AXI_wready,
  input  logic [1:0]              M_AXI_bresp,
  input  logic                    M_AXI_bvalid,
  output logic                    M_AXI_bready,
  output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [2:0]              M_AXI_arprot,
  output logic                    M_AXI_arvalid,
  input  logic                    M_AXI_arready,
  input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]              M_AXI_rresp,
  input  logic                    M_AXI_rvalid,
  output logic                    M_AXI_rready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      wait_cnt;

  assign M_AXI_awaddr = addr_q;
  assign M_AXI_araddr = addr_q;
  assign M_AXI_awprot = 3'b000;
  assign M_AXI_arprot = 3'b000;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      addr_q        <= '0;
      M_AXI_wdata   <= '0;
      M_AXI_wstrb   <= '0;
      M_AXI_awvalid <= 1'b0;
      M_AXI_wvalid  <= 1'b0;
      M_AXI_arvalid <= 1'b0;
      M_AXI_bready  <= 1'b0;
      M_AXI_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      timeout       <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            addr_q      <= cmd_addr;
            M_AXI_wdata <= cmd_wdata;
            M_AXI_wstrb <= cmd_wstrb;
            wait_cnt    <= '0;
            timeout     <= 1'b0;
            if (cmd_write) begin
              state         <= WR_REQ;
              M_AXI_awvalid <= 1'b1;
              M_AXI_wvalid  <= 1'b1;
            end else begin
              state         <= RD_REQ;
              M_AXI_arvalid <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          // A channel whose valid is already low has completed its handshake.
          if (M_AXI_awready) M_AXI_awvalid <= 1'b0;
          if (M_AXI_wready)  M_AXI_wvalid  <= 1'b0;
          if ((!M_AXI_awvalid || M_AXI_awready) && (!M_AXI_wvalid || M_AXI_wready)) begin
            state        <= WR_RESP;
            M_AXI_bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (M_AXI_bvalid) begin
            M_AXI_bready <= 1'b0;
            rsp_resp     <= M_AXI_bresp;
            rsp_rdata    <= '0;
            rsp_write    <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RD_REQ: begin
          if (M_AXI_arready) begin
            M_AXI_arvalid <= 1'b0;
            M_AXI_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (M_AXI_rvalid) begin
            M_AXI_rready <= 1'b0;
            rsp_rdata    <= M_AXI_rdata;
            rsp_resp     <= M_AXI_rresp;
            rsp_write    <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Timeout is purely observational; the AXI handshakes above never look at it.
      if (state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA}) begin
        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
        if (wait_cnt == CNT_MAX - CNT_W'(1)) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// tb/tb_axi_lite_master_cmd.sv - directed and randomized bench for axi_lite_master_cmd
module tb_axi_lite_master_cmd;
  localparam int TMO = 8;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXI_awaddr, M_AXI_wdata, M_AXI_araddr;
  logic [31:0] M_AXI_rdata = '0;
  logic [2:0]  M_AXI_awprot, M_AXI_arprot;
  logic [3:0]  M_AXI_wstrb;
  logic        M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid, M_AXI_bready, M_AXI_rready;
  logic        M_AXI_awready = 1'b0, M_AXI_wready = 1'b0, M_AXI_arready = 1'b0;
  logic        M_AXI_bvalid = 1'b0, M_AXI_rvalid = 1'b0;
  logic [1:0]  M_AXI_bresp = '0, M_AXI_rresp = '0;

  always #5 ACLK = ~ACLK;

  axi_lite_master_cmd #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout(timeout),
    .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awprot(M_AXI_awprot), .M_AXI_awvalid(M_AXI_awvalid),
    .M_AXI_awready(M_AXI_awready), .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready), .M_AXI_bresp(M_AXI_bresp),
    .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready), .M_AXI_araddr(M_AXI_araddr),
    .M_AXI_arprot(M_AXI_arprot), .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
    .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp), .M_AXI_rvalid(M_AXI_rvalid),
    .M_AXI_rready(M_AXI_rready)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave behaviour knobs and memories (slave_mem is written from the DUT's AXI outputs,
  // ref_mem from the commands issued, so they only agree if the DUT forwards data correctly).
  int          aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
  logic [1:0]  resp_cfg = 2'b00;
  logic        spur_r = 1'b0, spur_b = 1'b0;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  int          aw_hi = 0, w_hi = 0, ar_hi = 0, viol = 0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [3:0]  s_wstrb = '0;
  logic        p_aw = 1'b0, p_awr = 1'b0, p_w = 1'b0, p_wr = 1'b0, p_ar = 1'b0, p_arr = 1'b0, p_rst = 1'b1;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

  // Slave and protocol monitor share one negedge process so readiness ordering is deterministic.
  initial forever begin
    @(negedge ACLK);
    if (!ARESET && !p_rst) begin
      if (p_aw && !p_awr && (!M_AXI_awvalid || M_AXI_awaddr != p_awaddr)) viol++;
      if (p_w  && !p_wr  && (!M_AXI_wvalid  || M_AXI_wdata  != p_wdata))  viol++;
      if (p_ar && !p_arr && (!M_AXI_arvalid || M_AXI_araddr != p_araddr)) viol++;
    end
    if (M_AXI_bready && (M_AXI_awvalid || M_AXI_wvalid)) viol++;
    if (M_AXI_awprot != 3'b000 || M_AXI_arprot != 3'b000) viol++;
    if (M_AXI_awvalid) aw_hi++;
    if (M_AXI_wvalid)  w_hi++;
    if (M_AXI_arvalid) ar_hi++;

    if (M_AXI_awvalid) begin
      M_AXI_awready = (aw_cnt == aw_d);
      if (M_AXI_awready) s_awaddr = M_AXI_awaddr;
      aw_cnt++;
    end else begin M_AXI_awready = 1'b0; aw_cnt = 0; end
    if (M_AXI_wvalid) begin
      M_AXI_wready = (w_cnt == w_d);
      if (M_AXI_wready) begin s_wdata = M_AXI_wdata; s_wstrb = M_AXI_wstrb; end
      w_cnt++;
    end else begin M_AXI_wready = 1'b0; w_cnt = 0; end
    if (M_AXI_arvalid) begin
      M_AXI_arready = (ar_cnt == ar_d);
      if (M_AXI_arready) s_araddr = M_AXI_araddr;
      ar_cnt++;
    end else begin M_AXI_arready = 1'b0; ar_cnt = 0; end
    if (M_AXI_bready) begin
      M_AXI_bvalid = (b_cnt == b_d);
      M_AXI_bresp  = resp_cfg;
      if (M_AXI_bvalid) slave_mem[s_awaddr] = merge(slave_rd(s_awaddr), s_wdata, s_wstrb);
      b_cnt++;
    end else begin M_AXI_bvalid = spur_b; M_AXI_bresp = 2'b11; b_cnt = 0; end
    if (M_AXI_rready) begin
      M_AXI_rvalid = (r_cnt == r_d);
      M_AXI_rdata  = M_AXI_rvalid ? slave_rd(s_araddr) : 32'h0;
      M_AXI_rresp  = resp_cfg;
      r_cnt++;
    end else begin
      M_AXI_rvalid = spur_r;
      M_AXI_rdata  = spur_r ? 32'hDEAD_BEEF : 32'h0;
      M_AXI_rresp  = 2'b11;
      r_cnt = 0;
    end

    p_rst = ARESET;
    p_aw = M_AXI_awvalid; p_awr = M_AXI_awready; p_awaddr = M_AXI_awaddr;
    p_w  = M_AXI_wvalid;  p_wr  = M_AXI_wready;  p_wdata  = M_AXI_wdata;
    p_ar = M_AXI_arvalid; p_arr = M_AXI_arready; p_araddr = M_AXI_araddr;
  end

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge ACLK); #1; n++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    aw_hi = 0; w_hi = 0; ar_hi = 0;
    chk("timeout_cleared", 64'(timeout), 64'(0));
    chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
  endtask

  // Reference rule: waiting cycles are those between capture and response; response visible one later.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int awd, input int wd, input int bd, input int ard, input int rd,
                         input logic [1:0] rsp, input int hold, input logic spur);
    int          waiting, k;
    logic [31:0] exp_rdata;
    if (w) begin
      ref_mem[a] = merge(ref_rd(a), d, s);
      exp_rdata  = 32'h0;
      waiting    = 2 + ((awd > wd) ? awd : wd) + bd;
    end else begin
      exp_rdata  = ref_rd(a);
      waiting    = 2 + ard + rd;
    end
    aw_d = awd; w_d = wd; b_d = bd; ar_d = ard; r_d = rd; resp_cfg = rsp;
    spur_r = w & spur; spur_b = !w & spur;
    send_cmd(w, a, d, s);
    k = 0;
    while (!rsp_valid && k < 200) begin @(posedge ACLK); #1; k++; end
    chk("latency", 64'(k + 1), 64'(waiting + 1));
    chk("rsp_write", 64'(rsp_write), 64'(w));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    chk("rsp_resp", 64'(rsp_resp), 64'(rsp));
    chk("timeout_flag", 64'(timeout), 64'(waiting >= TMO));
    chk("aw_cycles", 64'(aw_hi), 64'(w ? awd + 1 : 0));
    chk("w_cycles", 64'(w_hi), 64'(w ? wd + 1 : 0));
    chk("ar_cycles", 64'(ar_hi), 64'(w ? 0 : ard + 1));
    for (int i = 0; i < hold; i++) begin
      @(posedge ACLK); #1;
      chk("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    @(posedge ACLK); #1;
    rsp_ready = 1'b0;
    chk("rsp_released", 64'(rsp_valid), 64'(0));
    chk("cmd_ready_after_rsp", 64'(cmd_ready), 64'(1));
    chk("timeout_sticky", 64'(timeout), 64'(waiting >= TMO));
    spur_r = 1'b0; spur_b = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
    chk({tag, "_valids"}, 64'({M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid, M_AXI_bready, M_AXI_rready}), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_fields"}, 64'({rsp_write, rsp_rdata, rsp_resp}), 64'(0));
    chk({tag, "_timeout"}, 64'(timeout), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        w;
    logic [31:0] a;
    slave_mem[32'h8] = 32'h1234_5678;
    ref_mem[32'h8]   = 32'h1234_5678;

    repeat (3) @(posedge ACLK);
    #1;
    chk_reset_state("reset");
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

    run_txn(1'b1, 32'h0, 32'h0000_00A5, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 1'b0);
    run_txn(1'b0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 1, 4, 2'b00, 0, 1'b0);
    run_txn(1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, 3, 0, 0, 0, 0, 2'b00, 0, 1'b0);
    run_txn(1'b0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 5, 1'b0);
    run_txn(1'b1, 32'hC, 32'h5555_AAAA, 4'h5, 0, 0, 0, 0, 0, 2'b10, 0, 1'b1);
    run_txn(1'b0, 32'hC, 32'h0, 4'h0, 0, 0, 0, 0, 1, 2'b01, 1, 1'b1);
    run_txn(1'b1, 32'h0, 32'h1111_2222, 4'h3, 3, 1, 2, 0, 0, 2'b00, 0, 1'b0);
    run_txn(1'b1, 32'h0, 32'h3333_4444, 4'hC, 3, 0, 3, 0, 0, 2'b00, 0, 1'b0);
    run_txn(1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 3) * 4);
      run_txn(w, a, $urandom, 4'($urandom_range(1, 15)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    ar_d = 1000000;
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    repeat (7) @(posedge ACLK);
    #1;
    chk("timeout_before_limit", 64'(timeout), 64'(0));
    @(posedge ACLK); #1;
    chk("timeout_at_limit", 64'(timeout), 64'(1));
    chk("arvalid_at_limit", 64'(M_AXI_arvalid), 64'(1));
    repeat (3) @(posedge ACLK);
    #1;
    chk("arvalid_held_after_timeout", 64'(M_AXI_arvalid), 64'(1));
    chk("timeout_held", 64'(timeout), 64'(1));
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk_reset_state("mid_reset");
    ARESET = 1'b0;
    ar_d = 0;
    @(posedge ACLK); #1;
    chk("cmd_ready_after_mid_reset", 64'(cmd_ready), 64'(1));
    chk("no_abandoned_rsp", 64'(rsp_valid), 64'(0));
    run_txn(1'b0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 1'b0);

    chk("protocol_violations", 64'(viol), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_cmd.md
AXI_LITE_MASTER_CMD -- requirements
Module: axi_lite_master_cmd

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width (32 or 64).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, wait-cycle limit per outstanding transaction (>=2).
REQ-004 SHALL have ports:
- ACLK  in  1  single clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when both high.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when both high.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
- rsp_resp  out  2  captured BRESP/RRESP.
- timeout  out  1  sticky wait-limit flag.
- M_AXI_awaddr/awprot/awvalid out ADDR_WIDTH/3/1; M_AXI_awready in 1.
- M_AXI_wdata/wstrb/wvalid out DATA_WIDTH/DATA_WIDTH/8/1; M_AXI_wready in 1.
- M_AXI_bresp in 2; M_AXI_bvalid in 1; M_AXI_bready out 1.
- M_AXI_araddr/arprot/arvalid out ADDR_WIDTH/3/1; M_AXI_arready in 1.
- M_AXI_rdata in DATA_WIDTH; M_AXI_rresp in 2; M_AXI_rvalid in 1; M_AXI_rready out 1.

Function
REQ-005 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP; one transaction outstanding at a time.
REQ-006 SHALL drive cmd_ready=1 only in IDLE (registered or state-decoded); command captured on cmd_valid&&cmd_ready.
REQ-007 SHALL, on write capture, enter WR_REQ and assert awvalid and wvalid together in the next cycle, with awaddr/wdata/wstrb from captured command.
REQ-008 SHALL deassert awvalid the cycle after its own awvalid&&awready handshake and wvalid likewise, independently; AW and W in either order or same cycle.
REQ-009 SHALL hold awaddr/wdata/wstrb stable and keep each valid high until its handshake (no withdrawal, including on timeout).
REQ-010 SHALL move WR_REQ->WR_RESP once both AW and W handshakes have completed; bready=1 only in WR_RESP.
REQ-011 SHALL, on bvalid&&bready, capture bresp into rsp_resp, set rsp_rdata=0, rsp_write=1, enter RSP.
REQ-012 SHALL, on read capture, enter RD_REQ asserting arvalid next cycle; on arvalid&&arready enter RD_DATA, arvalid low.
REQ-013 SHALL assert rready=1 only in RD_DATA; on rvalid&&rready capture rdata/rresp, rsp_write=0, enter RSP.
REQ-014 SHALL assert rsp_valid only in RSP, outputs stable until rsp_valid&&rsp_ready, then return to IDLE; cmd_ready high the following cycle.
REQ-015 SHALL drive awprot=arprot=3'b000 constant.
REQ-016 SHALL count cycles spent in WR_REQ/WR_RESP/RD_REQ/RD_DATA with a counter cleared on each command capture, saturating; when count reaches TIMEOUT_CYCLES, set timeout=1.
REQ-017 SHALL keep timeout set until ARESET or next command capture; timeout SHALL NOT alter AXI signalling.
REQ-018 SHALL ignore bvalid outside WR_RESP and rvalid outside RD_DATA (no capture, no state change).
REQ-019 SHALL give minimum latency: write command to rsp_valid = 3 cycles with zero-wait slave (AW/W cycle 1, B cycle 2, RSP cycle 3); read likewise 3 cycles.

Reset
REQ-020 SHALL, while ARESET=1 on a clock edge, enter IDLE and drive cmd_ready=0, awvalid=wvalid=arvalid=0, bready=rready=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_resp=0, timeout=0, counter=0; cmd_ready=1 the first cycle after ARESET falls.
REQ-021 SHALL, on ARESET mid-transaction, abandon it with no response generated.

Verification
REQ-022 Write addr 0x0, wdata 0x0000_00A5, wstrb 0xF, zero-wait slave -> awvalid/wvalid high one cycle, rsp_valid 3 cycles after capture, rsp_write=1, rsp_resp=00.
REQ-023 Read addr 0x8, slave returns rdata 0x1234_5678 rresp 00 after 4 wait cycles -> rsp_rdata=0x1234_5678, rsp_write=0, arvalid held until arready.
REQ-024 Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, bready only after both done.
REQ-025 rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable; cmd_ready stays 0; new command accepted after release.
REQ-026 TIMEOUT_CYCLES=8, slave never asserts arready -> timeout=1 after 8 waiting cycles, arvalid still high; ARESET pulse -> all outputs to reset values.
REQ-027 Slave returns bresp=2'b10 -> rsp_resp=2'b10; spurious rvalid during write ignored.
